// File: rtl/ex_div_seq.sv
// Purpose: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer, radix-2 restoring, one quotient bit per cycle.
// Latency: XLEN cycles after accept for normal ops; 0 extra cycles for divide-by-zero and signed overflow.
// Backpressure: stall holds IF/ID/EX while an op is accepted or running; flush squashes and returns to idle.
module ex_div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct_3,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quot;
    logic            op_rem;
    logic            op_uns;
    logic            sign_q;
    logic            sign_r;

    // One restoring step: bring the next dividend bit into the partial remainder.
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_sub;
    logic            rem_ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quot_nx;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    always_comb begin
        rem_sh  = {rem, dvd[cnt]};
        rem_sub = rem_sh - {1'b0, dvs};
        rem_ge  = (rem_sh >= {1'b0, dvs});
        rem_nx  = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
        quot_nx = {quot[XLEN-2:0], rem_ge};
        q_fin   = (!op_uns && sign_q) ? (~quot_nx + 1'b1) : quot_nx;
        r_fin   = (!op_uns && sign_r) ? (~rem_nx + 1'b1) : rem_nx;
    end

    // Operand decode for the op being offered this cycle.
    logic            acc_ok;
    logic            in_signed;
    logic            neg1;
    logic            neg2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        acc_ok      = (state != S_RUN) && start && funct_3[2] && !flush;
        in_signed   = !funct_3[0];
        neg1        = in_signed && in1[XLEN-1];
        neg2        = in_signed && in2[XLEN-1];
        abs1        = neg1 ? (~in1 + 1'b1) : in1;
        abs2        = neg2 ? (~in2 + 1'b1) : in2;
        div_zero    = (in2 == '0);
        ovf         = in_signed && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
        special_res = '0;
        if (div_zero)
            special_res = funct_3[1] ? in1 : '1;
        else if (ovf)
            special_res = funct_3[1] ? '0 : in1;
    end

    assign stall = acc_ok || ((state == S_RUN) && !flush);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quot   <= '0;
            op_rem <= 1'b0;
            op_uns <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        rem  <= rem_nx;
                        quot <= quot_nx;
                        if (cnt == '0) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= op_rem ? r_fin : q_fin;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    if (acc_ok) begin
                        op_rem <= funct_3[1];
                        op_uns <= funct_3[0];
                        dvd    <= abs1;
                        dvs    <= abs2;
                        sign_q <= neg1 ^ neg2;
                        sign_r <= neg1;
                        rem    <= '0;
                        quot   <= '0;
                        busy   <= 1'b1;
                        if (div_zero || ovf) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= special_res;
                        end else begin
                            state <= S_RUN;
                            done  <= 1'b0;
                            cnt   <= CW'(XLEN - 1);
                        end
                    end else begin
                        // Flush, no start, or a non-divide start: fall back to idle.
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: latency, results, special cases, flush, back-to-back and async reset.
module tb_ex_div_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  funct_3;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    ex_div_seq #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct_3 (funct_3),
        .in1     (in1),
        .in2     (in2),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an op, let it be accepted, and wait for done; lat counts edges after the accept edge.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        int n;
        @(posedge clk); #1;
        start = 1'b1; funct_3 = f3; in1 = a; in2 = b;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL %s stall_pre got=%b exp=1", name, stall);
        end
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        checks++;
        if (stall !== (lat != 0)) begin
            errors++;
            $display("FAIL %s stall_post got=%b exp=%b", name, stall, (lat != 0));
        end
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s latency got=%0d exp=%0d", name, n, lat);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result got=%h exp=%h", name, result, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after got done=%b busy=%b exp 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b result=%h stall=%b exp all 0",
                     busy, done, result, stall);
        end
    endtask

    task automatic test_ignore_nondiv;
        @(posedge clk); #1;
        start = 1'b1; funct_3 = 3'b001; in1 = 32'd10; in2 = 32'd2;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL nondiv_stall got=%b exp=0", stall);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nondiv_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_unsigned;
        run_op(F_DIVU, 32'd100, 32'd7, 32'd14, 32, "divu_100_7");
        run_op(F_REMU, 32'd100, 32'd7, 32'd2, 32, "remu_100_7");
        run_op(F_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32, "divu_max_1");
    endtask

    task automatic test_signed;
        run_op(F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, "div_m7_2");
        run_op(F_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, "rem_m7_2");
        run_op(F_REM, 32'd7, 32'hFFFFFFFE, 32'd1, 32, "rem_7_m2");
        run_op(F_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32, "div_7_m2");
    endtask

    task automatic test_special;
        run_op(F_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 0, "divu_by0");
        run_op(F_REM, 32'd5, 32'd0, 32'd5, 0, "rem_by0");
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf");
        run_op(F_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0, "rem_ovf");
    endtask

    task automatic test_flush;
        int seen;
        @(posedge clk); #1;
        start = 1'b1; funct_3 = F_DIVU; in1 = 32'd100; in2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall got=%b exp=0", stall);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got busy=%b done=%b stall=%b exp 0 0 0", busy, done, stall);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_nodone got=%0d pulses exp=0", seen);
        end
        run_op(F_DIVU, 32'd9, 32'd3, 32'd3, 32, "divu_after_flush");
    endtask

    task automatic test_back_to_back;
        int n;
        @(posedge clk); #1;
        start = 1'b1; funct_3 = F_DIVU; in1 = 32'd9; in2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 32 || result !== 32'd3) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d result=%h exp lat=32 result=3", n, result);
        end
        start = 1'b1; in1 = 32'd8; in2 = 32'd2;
        n = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end while (done !== 1'b1 && n < 40);
        checks++;
        if (n !== 33 || result !== 32'd4) begin
            errors++;
            $display("FAIL b2b_second got gap=%0d result=%h exp gap=33 result=4", n, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1;
        start = 1'b1; funct_3 = F_DIVU; in1 = 32'd50; in2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b result=%h exp 0 0 0", busy, done, result);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_op(F_DIVU, 32'd50, 32'd5, 32'd10, 32, "divu_after_reset");
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; funct_3 = 3'b000; in1 = '0; in2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        test_ignore_nondiv();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
